// File: rtl/grn_node_lut_if.sv
// Control/data bundle for one gene-regulatory-network node with two trajectories.
// The slave modport is the node; the master modport is the network or stimulus side.
interface grn_node_lut_if #(
  parameter int unsigned NUM_IN = 2,
  parameter int unsigned CNT_W  = 8
);
  logic              i_start;
  logic              i_reset_nos;
  logic              i_start_s0;
  logic              i_start_s1;
  logic              i_init_state;
  logic [NUM_IN-1:0] i_in_s0;
  logic [NUM_IN-1:0] i_in_s1;
  logic              o_s0;
  logic              o_s1;
  logic              o_node_s0;
  logic              o_node_s1;
  logic              o_diff;
  logic [CNT_W-1:0]  o_flip_cnt;

  modport slave (
    input  i_start, i_reset_nos, i_start_s0, i_start_s1, i_init_state, i_in_s0, i_in_s1,
    output o_s0, o_s1, o_node_s0, o_node_s1, o_diff, o_flip_cnt
  );

  modport master (
    output i_start, i_reset_nos, i_start_s0, i_start_s1, i_init_state, i_in_s0, i_in_s1,
    input  o_s0, o_s1, o_node_s0, o_node_s1, o_diff, o_flip_cnt
  );
endinterface

// File: rtl/grn_node_lut.sv
// Boolean network node: LUT-driven next state for a delayed (s0) and an undelayed (s1)
// trajectory, with a saturating count of s0 value changes.
module grn_node_lut #(
  parameter int unsigned                 NUM_IN = 2,
  parameter logic [(1 << NUM_IN) - 1:0]  LUT    = 4'b0110,
  parameter int unsigned                 DELAY  = 2,
  parameter int unsigned                 CNT_W  = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  grn_node_lut_if.slave     bus
);

  localparam int unsigned     PH_W    = $clog2(DELAY + 1);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(DELAY - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic              r_s0;
  logic              r_s1;
  logic [PH_W-1:0]   r_ph;
  logic [CNT_W-1:0]  r_flip_cnt;

  logic w_acc_s0;
  logic w_acc_s1;
  logic w_lut_s0;
  logic w_lut_s1;
  logic w_upd_s0;

  assign w_acc_s0 = bus.i_start & bus.i_start_s0;
  assign w_acc_s1 = bus.i_start & bus.i_start_s1;
  assign w_lut_s0 = LUT[bus.i_in_s0];
  assign w_lut_s1 = LUT[bus.i_in_s1];
  // s0 only takes a new value on the last phase of its delay window
  assign w_upd_s0 = w_acc_s0 && (r_ph == PH_LAST);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_s0       <= 1'b0;
      r_s1       <= 1'b0;
      r_ph       <= '0;
      r_flip_cnt <= '0;
    end else if (bus.i_reset_nos) begin
      r_s0       <= bus.i_init_state;
      r_s1       <= bus.i_init_state;
      r_ph       <= PH_LAST;
      r_flip_cnt <= '0;
    end else begin
      if (w_acc_s0) begin
        if (w_upd_s0) begin
          r_s0 <= w_lut_s0;
          r_ph <= '0;
          if ((w_lut_s0 != r_s0) && (r_flip_cnt != CNT_MAX)) begin
            r_flip_cnt <= r_flip_cnt + CNT_W'(1);
          end
        end else begin
          r_ph <= r_ph + PH_W'(1);
        end
      end
      if (w_acc_s1) begin
        r_s1 <= w_lut_s1;
      end
    end
  end

  assign bus.o_s0       = r_s0;
  assign bus.o_s1       = r_s1;
  assign bus.o_node_s0  = r_s0;
  assign bus.o_node_s1  = r_s1;
  assign bus.o_diff     = r_s0 ^ r_s1;
  assign bus.o_flip_cnt = r_flip_cnt;

endmodule

// File: tb/tb_grn_node_lut.sv
// Directed bench for grn_node_lut: XOR LUT node with DELAY=2 (dut0) and DELAY=1 (dut1).
module tb_grn_node_lut;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;
  logic [5:0] st;

  grn_node_lut_if #(.NUM_IN(2), .CNT_W(2)) bus0 ();
  grn_node_lut_if #(.NUM_IN(2), .CNT_W(2)) bus1 ();

  grn_node_lut #(.NUM_IN(2), .LUT(4'b0110), .DELAY(2), .CNT_W(2)) dut0 (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus0.slave)
  );

  grn_node_lut #(.NUM_IN(2), .LUT(4'b0110), .DELAY(1), .CNT_W(2)) dut1 (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus0.i_start = 1'b0; bus0.i_reset_nos = 1'b0; bus0.i_start_s0 = 1'b0;
    bus0.i_start_s1 = 1'b0; bus0.i_init_state = 1'b0; bus0.i_in_s0 = 2'b00; bus0.i_in_s1 = 2'b00;
    bus1.i_start = 1'b0; bus1.i_reset_nos = 1'b0; bus1.i_start_s0 = 1'b0;
    bus1.i_start_s1 = 1'b0; bus1.i_init_state = 1'b0; bus1.i_in_s0 = 2'b00; bus1.i_in_s1 = 2'b00;
  endtask

  // state vector order: {s0, s1, ph[1:0], flip_cnt[1:0]}
  task automatic test_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    st = {bus0.o_s0, bus0.o_s1, dut0.r_ph, bus0.o_flip_cnt};
    n_cmp++;
    if (st !== 6'b00_00_00) begin n_err++; $display("FAIL reset_state0 got=%b exp=000000", st); end
    n_cmp++;
    if (bus0.o_diff !== 1'b0) begin n_err++; $display("FAIL reset_diff got=%b exp=0", bus0.o_diff); end
    n_cmp++;
    if ({bus1.o_s0, bus1.o_s1, bus1.o_flip_cnt} !== 4'b0000) begin
      n_err++; $display("FAIL reset_state1 got=%b exp=0000", {bus1.o_s0, bus1.o_s1, bus1.o_flip_cnt});
    end
  endtask

  task automatic test_saturate();
    logic [1:0] exp_cnt;
    logic       exp_s0;
    bus1.i_reset_nos = 1'b1; bus1.i_init_state = 1'b0;
    tick();
    bus1.i_reset_nos = 1'b0;
    bus1.i_start = 1'b1;
    exp_s0 = 1'b0;
    exp_cnt = 2'd0;
    for (int k = 0; k < 7; k++) begin
      bus1.i_in_s0 = (k % 2 == 0) ? 2'b01 : 2'b00;
      bus1.i_start_s0 = 1'b1;
      tick();
      bus1.i_start_s0 = 1'b0;
      exp_s0 = ~exp_s0;
      if (exp_cnt != 2'd3) exp_cnt = exp_cnt + 2'd1;
      n_cmp++;
      if ({bus1.o_s0, dut1.r_ph, bus1.o_flip_cnt} !== {exp_s0, 1'b0, exp_cnt}) begin
        n_err++;
        $display("FAIL saturate_k%0d got=%b exp=%b", k, {bus1.o_s0, dut1.r_ph, bus1.o_flip_cnt}, {exp_s0, 1'b0, exp_cnt});
      end
    end
    bus1.i_start = 1'b0;
  endtask

  task automatic test_delay_seq();
    bus0.i_reset_nos = 1'b1; bus0.i_init_state = 1'b1;
    tick();
    bus0.i_reset_nos = 1'b0;
    st = {bus0.o_s0, bus0.o_s1, dut0.r_ph, bus0.o_flip_cnt};
    n_cmp++;
    if (st !== 6'b11_01_00) begin n_err++; $display("FAIL nos_init1 got=%b exp=110100", st); end
    bus0.i_start = 1'b1; bus0.i_in_s0 = 2'b01; bus0.i_start_s0 = 1'b1;
    tick();
    bus0.i_start_s0 = 1'b0;
    st = {bus0.o_s0, bus0.o_s1, dut0.r_ph, bus0.o_flip_cnt};
    n_cmp++;
    if (st !== 6'b11_00_00) begin n_err++; $display("FAIL delay_pulse1 got=%b exp=110000", st); end
    bus0.i_in_s0 = 2'b11; bus0.i_start_s0 = 1'b1;
    tick();
    bus0.i_start_s0 = 1'b0;
    st = {bus0.o_s0, bus0.o_s1, dut0.r_ph, bus0.o_flip_cnt};
    n_cmp++;
    if (st !== 6'b11_01_00) begin n_err++; $display("FAIL delay_pulse2 got=%b exp=110100", st); end
    bus0.i_start_s0 = 1'b1;
    tick();
    bus0.i_start_s0 = 1'b0;
    st = {bus0.o_s0, bus0.o_s1, dut0.r_ph, bus0.o_flip_cnt};
    n_cmp++;
    if (st !== 6'b01_00_01) begin n_err++; $display("FAIL delay_pulse3 got=%b exp=010001", st); end
  endtask

  task automatic test_s1_diff();
    bus0.i_reset_nos = 1'b1; bus0.i_init_state = 1'b1;
    tick();
    bus0.i_reset_nos = 1'b0;
    bus0.i_in_s1 = 2'b10; bus0.i_start_s1 = 1'b1;
    tick();
    bus0.i_start_s1 = 1'b0;
    n_cmp++;
    if ({bus0.o_s1, bus0.o_diff} !== 2'b10) begin
      n_err++; $display("FAIL s1_pulse1 got=%b exp=10", {bus0.o_s1, bus0.o_diff});
    end
    bus0.i_in_s1 = 2'b11; bus0.i_start_s1 = 1'b1;
    tick();
    bus0.i_start_s1 = 1'b0;
    n_cmp++;
    if ({bus0.o_s0, bus0.o_s1, bus0.o_diff} !== 3'b101) begin
      n_err++; $display("FAIL s1_pulse2 got=%b exp=101", {bus0.o_s0, bus0.o_s1, bus0.o_diff});
    end
    n_cmp++;
    if ({bus0.o_node_s0, bus0.o_node_s1} !== 2'b10) begin
      n_err++; $display("FAIL node_copy got=%b exp=10", {bus0.o_node_s0, bus0.o_node_s1});
    end
  endtask

  task automatic test_hold();
    bus0.i_start = 1'b0; bus0.i_start_s0 = 1'b1; bus0.i_start_s1 = 1'b1;
    bus0.i_in_s0 = 2'b11; bus0.i_in_s1 = 2'b01;
    for (int k = 0; k < 5; k++) begin
      tick();
      st = {bus0.o_s0, bus0.o_s1, dut0.r_ph, bus0.o_flip_cnt};
      n_cmp++;
      if (st !== 6'b10_01_00) begin n_err++; $display("FAIL hold_c%0d got=%b exp=100100", k, st); end
    end
    bus0.i_start_s0 = 1'b0; bus0.i_start_s1 = 1'b0;
  endtask

  task automatic test_back_to_back();
    bus0.i_start = 1'b1; bus0.i_start_s0 = 1'b1; bus0.i_start_s1 = 1'b1;
    bus0.i_in_s0 = 2'b11; bus0.i_in_s1 = 2'b01;
    tick();
    bus0.i_start_s0 = 1'b0; bus0.i_start_s1 = 1'b0;
    st = {bus0.o_s0, bus0.o_s1, dut0.r_ph, bus0.o_flip_cnt};
    n_cmp++;
    if (st !== 6'b01_00_01) begin n_err++; $display("FAIL dual_strobe got=%b exp=010001", st); end
    n_cmp++;
    if (bus0.o_diff !== 1'b1) begin n_err++; $display("FAIL dual_diff got=%b exp=1", bus0.o_diff); end
  endtask

  task automatic test_nos_priority();
    bus0.i_start = 1'b1; bus0.i_reset_nos = 1'b1; bus0.i_init_state = 1'b0;
    bus0.i_start_s0 = 1'b1; bus0.i_start_s1 = 1'b1;
    bus0.i_in_s0 = 2'b01; bus0.i_in_s1 = 2'b01;
    tick();
    bus0.i_reset_nos = 1'b0; bus0.i_start_s0 = 1'b0; bus0.i_start_s1 = 1'b0;
    st = {bus0.o_s0, bus0.o_s1, dut0.r_ph, bus0.o_flip_cnt};
    n_cmp++;
    if (st !== 6'b00_01_00) begin n_err++; $display("FAIL nos_priority got=%b exp=000100", st); end
  endtask

  task automatic test_rst_priority();
    bus0.i_reset_nos = 1'b1; bus0.i_init_state = 1'b1;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0; bus0.i_reset_nos = 1'b0;
    st = {bus0.o_s0, bus0.o_s1, dut0.r_ph, bus0.o_flip_cnt};
    n_cmp++;
    if (st !== 6'b00_00_00) begin n_err++; $display("FAIL rst_over_nos got=%b exp=000000", st); end
    // first pulse after rst only advances the phase; the second updates s0
    bus0.i_start = 1'b1; bus0.i_in_s0 = 2'b01; bus0.i_start_s0 = 1'b1;
    tick();
    st = {bus0.o_s0, bus0.o_s1, dut0.r_ph, bus0.o_flip_cnt};
    n_cmp++;
    if (st !== 6'b00_01_00) begin n_err++; $display("FAIL post_rst_pulse1 got=%b exp=000100", st); end
    tick();
    bus0.i_start_s0 = 1'b0;
    st = {bus0.o_s0, bus0.o_s1, dut0.r_ph, bus0.o_flip_cnt};
    n_cmp++;
    if (st !== 6'b10_00_01) begin n_err++; $display("FAIL post_rst_pulse2 got=%b exp=100001", st); end
  endtask

  task automatic test_held_strobe();
    bus0.i_start = 1'b1; bus0.i_in_s0 = 2'b00; bus0.i_start_s0 = 1'b1;
    tick();
    st = {bus0.o_s0, bus0.o_s1, dut0.r_ph, bus0.o_flip_cnt};
    n_cmp++;
    if (st !== 6'b10_01_01) begin n_err++; $display("FAIL held_c0 got=%b exp=100101", st); end
    tick();
    bus0.i_start_s0 = 1'b0;
    st = {bus0.o_s0, bus0.o_s1, dut0.r_ph, bus0.o_flip_cnt};
    n_cmp++;
    if (st !== 6'b00_00_10) begin n_err++; $display("FAIL held_c1 got=%b exp=000010", st); end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b0;
    idle_inputs();
    test_reset();
    test_saturate();
    test_delay_seq();
    test_s1_diff();
    test_hold();
    test_back_to_back();
    test_nos_priority();
    test_rst_priority();
    test_held_strobe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
